// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB (plus a sticky TRAP on illegal opcodes),
// registers the immediate type and instruction class in DECODE, and drives
// all datapath strobes combinationally from the registered state and class.
//
// Memory handshake: mem_req is the valid and mem_ready is the ready. An access
// completes in the cycle both are 1. Once mem_req is raised in FETCH or MEM it
// stays high until that completion, or until rst (which forces every strobe
// low in the cycle it is sampled).
module multicycle_ctrl #(
    parameter int unsigned RESET_PC_HOLD = 0,
    parameter int unsigned RETIRE_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                branch_taken,
    output logic [2:0]          imm_type,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mem_is_data,
    output logic                alu_src_a,
    output logic                alu_src_b,
    output logic                reg_write,
    output logic [1:0]          wb_sel,
    output logic [2:0]          state,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // CL_NONE doubles as the "illegal opcode" result of the decoder.
    typedef enum logic [3:0] {
        CL_NONE   = 4'd0,
        CL_OP     = 4'd1,
        CL_OPIMM  = 4'd2,
        CL_LOAD   = 4'd3,
        CL_STORE  = 4'd4,
        CL_LUI    = 4'd5,
        CL_AUIPC  = 4'd6,
        CL_BRANCH = 4'd7,
        CL_JAL    = 4'd8,
        CL_JALR   = 4'd9
    } class_t;

    localparam logic [2:0] IMM_I    = 3'd0;
    localparam logic [2:0] IMM_B    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_U    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;
    localparam logic [2:0] IMM_NONE = 3'd7;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [3:0]          HOLD_INIT = 4'(RESET_PC_HOLD);
    localparam logic [RETIRE_W-1:0] RET_ONE   = RETIRE_W'(1);

    state_t              state_q, state_d;
    class_t              class_q, class_d;
    logic [2:0]          imm_q, imm_d;
    logic                illegal_q, illegal_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic [3:0]          hold_q, hold_d;

    class_t              dec_class;
    logic [2:0]          dec_imm;
    logic [6:0]          opcode;
    logic                retire;
    logic                unused_instr_bits;

    assign opcode            = instr[6:0];
    assign unused_instr_bits = ^instr[31:7];

    // Opcode decoder: instruction class and immediate format from instr[6:0].
    always_comb begin
        dec_class = CL_NONE;
        dec_imm   = IMM_NONE;
        case (opcode)
            7'b0110111: begin dec_class = CL_LUI;    dec_imm = IMM_U;    end
            7'b0010111: begin dec_class = CL_AUIPC;  dec_imm = IMM_U;    end
            7'b1101111: begin dec_class = CL_JAL;    dec_imm = IMM_J;    end
            7'b1100111: begin dec_class = CL_JALR;   dec_imm = IMM_I;    end
            7'b1100011: begin dec_class = CL_BRANCH; dec_imm = IMM_B;    end
            7'b0000011: begin dec_class = CL_LOAD;   dec_imm = IMM_I;    end
            7'b0100011: begin dec_class = CL_STORE;  dec_imm = IMM_S;    end
            7'b0010011: begin dec_class = CL_OPIMM;  dec_imm = IMM_I;    end
            7'b0110011: begin dec_class = CL_OP;     dec_imm = IMM_NONE; end
            default:    begin dec_class = CL_NONE;   dec_imm = IMM_NONE; end
        endcase
    end

    // Next-state, register updates and strobe decode from the registered state/class.
    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;
        retired_d   = retired_q;
        hold_d      = hold_q;
        retire      = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_PLUS4;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_is_data = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;
        reg_write   = 1'b0;
        wb_sel      = WB_ALU;

        case (state_q)
            ST_FETCH: begin
                // The post-reset hold delays only the very first fetch.
                if (hold_q != 4'd0) begin
                    hold_d = hold_q - 4'd1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_PLUS4;
                        state_d  = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                imm_d   = dec_imm;
                if (dec_class == CL_NONE) begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (class_q)
                    CL_OP: begin
                        state_d = ST_WB;
                    end
                    CL_OPIMM: begin
                        alu_src_b = 1'b1;
                        state_d   = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_b = 1'b1;
                        state_d   = ST_MEM;
                    end
                    CL_LUI: begin
                        state_d = ST_WB;
                    end
                    CL_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = ST_WB;
                    end
                    CL_BRANCH: begin
                        pc_write = branch_taken;
                        pc_src   = PC_REL;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CL_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_REL;
                        state_d  = ST_WB;
                    end
                    CL_JALR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JALR;
                        state_d  = ST_WB;
                    end
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                mem_is_data = 1'b1;
                mem_we      = (class_q == CL_STORE);
                if (mem_ready) begin
                    if (class_q == CL_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                case (class_q)
                    CL_LOAD:          wb_sel = WB_LOAD;
                    CL_JAL, CL_JALR:  wb_sel = WB_LINK;
                    CL_LUI:           wb_sel = WB_IMM;
                    default:          wb_sel = WB_ALU;
                endcase
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (retire) begin
            retired_d = retired_q + RET_ONE;
        end

        // Reset wins over everything: no strobe may fire in a reset cycle.
        if (rst) begin
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = PC_PLUS4;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_is_data = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 1'b0;
            reg_write   = 1'b0;
            wb_sel      = WB_ALU;
        end
    end

    // State, class, immediate type, sticky flag, retire counter and fetch hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            class_q   <= CL_NONE;
            imm_q     <= IMM_NONE;
            illegal_q <= 1'b0;
            retired_q <= '0;
            hold_q    <= HOLD_INIT;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            hold_q    <= hold_d;
        end
    end

    assign state    = state_q;
    assign imm_type = imm_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule
